// File: rtl/fifo_burst_reader_if.sv
// Read-side FIFO port plus the outgoing valid/ready beat stream of the burst reader.
// master is the reader; slave is the FIFO/downstream environment.
interface fifo_burst_reader_if #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
);
   logic [DSIZE-1:0] rdata;
   logic             rempty;
   logic [ASIZE:0]   rdepth;
   logic             rinc;
   logic [DSIZE-1:0] m_data;
   logic             m_valid;
   logic             m_last;
   logic             m_ready;

   modport master (
      input  rdata, rempty, rdepth, m_ready,
      output rinc, m_data, m_valid, m_last
   );

   modport slave (
      output rdata, rempty, rdepth, m_ready,
      input  rinc, m_data, m_valid, m_last
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains the read side of the dual-clock FIFO into valid/ready bursts of BURST_LEN beats,
// flushing a shorter burst on timeout or on request.
module fifo_burst_reader #(
   parameter int DSIZE     = 8,
   parameter int ASIZE     = 4,
   parameter int BURST_LEN = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic                rclk,
   input  logic                rrst,
   fifo_burst_reader_if.master bus,
   input  logic                flush,
   output logic                busy,
   output logic                timeout_evt
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [ASIZE:0] FULL_LEN   = (ASIZE + 1)'(BURST_LEN);
   localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]  TIMER_MAX  = TW'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

   state_t           state_reg, state_next;
   logic [ASIZE:0]   remaining_reg, remaining_next;
   logic [TW-1:0]    timer_reg, timer_next;
   logic [DSIZE-1:0] m_data_reg, m_data_next;
   logic             m_valid_reg, m_valid_next;
   logic             m_last_reg, m_last_next;
   logic             timeout_reg, timeout_next;
   logic             avail;
   logic             pop;

   always_ff @(posedge rclk) begin
      if (rrst) begin
         state_reg     <= S_IDLE;
         remaining_reg <= '0;
         timer_reg     <= '0;
         m_data_reg    <= '0;
         m_valid_reg   <= 1'b0;
         m_last_reg    <= 1'b0;
         timeout_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         timer_reg     <= timer_next;
         m_data_reg    <= m_data_next;
         m_valid_reg   <= m_valid_next;
         m_last_reg    <= m_last_next;
         timeout_reg   <= timeout_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      timer_next     = timer_reg;
      m_data_next    = m_data_reg;
      m_valid_next   = m_valid_reg;
      m_last_next    = m_last_reg;
      timeout_next   = 1'b0;

      // A non-empty flag with zero depth is a CDC transient; treat it as empty.
      avail = !bus.rempty && (bus.rdepth != '0);
      pop   = (state_reg == S_BURST) && (remaining_reg != '0) && !bus.rempty &&
              (!m_valid_reg || bus.m_ready);

      case (state_reg)
         S_IDLE: begin
            if (avail) begin
               if (bus.rdepth >= FULL_LEN) begin
                  state_next     = S_BURST;
                  remaining_next = FULL_LEN;
               end else begin
                  state_next = S_WAIT;
                  timer_next = '0;
               end
            end
         end
         S_WAIT: begin
            if (timer_reg != TIMER_MAX) begin
               timer_next = timer_reg + 1'b1;
            end
            // A full burst wins over flush, and flush wins over timeout.
            if (bus.rdepth >= FULL_LEN) begin
               state_next     = S_BURST;
               remaining_next = FULL_LEN;
            end else if (flush) begin
               state_next     = S_BURST;
               remaining_next = bus.rdepth;
            end else if (timer_reg == TIMER_LAST) begin
               state_next     = S_BURST;
               remaining_next = bus.rdepth;
               timeout_next   = 1'b1;
            end
         end
         S_BURST: begin
            if (m_valid_reg && bus.m_ready && m_last_reg) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase

      if (pop) begin
         m_data_next    = bus.rdata;
         m_valid_next   = 1'b1;
         m_last_next    = (remaining_reg == (ASIZE + 1)'(1));
         remaining_next = remaining_reg - 1'b1;
      end else if (m_valid_reg && bus.m_ready) begin
         m_valid_next = 1'b0;
         m_last_next  = 1'b0;
      end
   end

   assign bus.rinc    = pop && !rrst;
   assign bus.m_data  = m_data_reg;
   assign bus.m_valid = m_valid_reg;
   assign bus.m_last  = m_last_reg;
   assign busy        = (state_reg != S_IDLE);
   assign timeout_evt = timeout_reg;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: an array-backed FIFO feeds the DUT and every
// accepted beat is checked against an expected word/last stream built from burst arithmetic.
module tb_fifo_burst_reader;
   localparam int DSIZE     = 8;
   localparam int ASIZE     = 5;
   localparam int BURST_LEN = 8;
   localparam int TIMEOUT   = 16;

   logic rclk  = 1'b0;
   logic rrst  = 1'b1;
   logic flush = 1'b0;
   logic busy;
   logic timeout_evt;

   fifo_burst_reader_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

   fifo_burst_reader #(
      .DSIZE(DSIZE), .ASIZE(ASIZE), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
   ) dut (
      .rclk(rclk),
      .rrst(rrst),
      .bus(bus),
      .flush(flush),
      .busy(busy),
      .timeout_evt(timeout_evt)
   );

   always #5 rclk = ~rclk;

   // FIFO model: words written by the stimulus, popped on rinc, emptied by rrst.
   logic [7:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign bus.rdata  = mem[rd_ptr[7:0]];
   assign bus.rempty = (wr_ptr == rd_ptr);
   assign bus.rdepth = (ASIZE + 1)'(wr_ptr - rd_ptr);

   always @(posedge rclk) begin
      if (rrst) rd_ptr <= wr_ptr;
      else if (bus.rinc) rd_ptr <= rd_ptr + 1;
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int first_rinc, last_rinc, rinc_cnt, first_beat, last_beat, beat_cnt, to_cnt, to_cyc;
   logic [7:0] sb_data [$];
   bit         sb_last [$];
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = '0;
   logic       prev_last  = 1'b0;
   logic       prev_to    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_stats();
      first_rinc = -1; last_rinc = -1; rinc_cnt = 0;
      first_beat = -1; last_beat = -1; beat_cnt = 0;
      to_cnt = 0; to_cyc = -1;
   endtask

   // Per-cycle comparison against the expected stream and handshake rules.
   task automatic monitor();
      logic [7:0] exp_d;
      bit         exp_l;
      cyc++;
      if (rrst) begin
         prev_stall = 1'b0;
         prev_to    = 1'b0;
      end else begin
         if (bus.rinc) begin
            rinc_cnt++;
            if (first_rinc < 0) first_rinc = cyc;
            last_rinc = cyc;
            check("no_underflow", 32'(bus.rempty), 0);
            check("pop_when_free", 32'(bus.m_valid && !bus.m_ready), 0);
         end
         if (prev_stall) begin
            check("hold_valid", 32'(bus.m_valid), 1);
            check("hold_data", 32'(bus.m_data), 32'(prev_data));
            check("hold_last", 32'(bus.m_last), 32'(prev_last));
         end
         if (bus.m_valid || bus.rinc) check("busy_active", 32'(busy), 1);
         if (timeout_evt) begin
            to_cnt++;
            to_cyc = cyc;
            check("evt_one_cycle", 32'(prev_to), 0);
         end
         if (bus.m_valid && bus.m_ready) begin
            beat_cnt++;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            if (sb_data.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat: got data 0x%0h last %0d, expected no beat (cycle %0d)",
                        bus.m_data, bus.m_last, cyc);
            end else begin
               exp_d = sb_data.pop_front();
               exp_l = sb_last.pop_front();
               check("beat_data", 32'(bus.m_data), 32'(exp_d));
               check("beat_last", 32'(bus.m_last), 32'(exp_l));
            end
            $display("beat cyc=%0d data=0x%02h last=%0d", cyc, bus.m_data, bus.m_last);
         end
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
         prev_last  = bus.m_last;
         prev_to    = timeout_evt;
      end
   endtask

   task automatic tick();
      @(negedge rclk);
      monitor();
      @(posedge rclk);
      #2;
   endtask

   task automatic write_words(input int base, input int n);
      for (int i = 0; i < n; i++) mem[8'(wr_ptr + i)] = 8'(base + i);
      wr_ptr = wr_ptr + n;
   endtask

   // Words drained in order, cut into BURST_LEN bursts; the tail burst ends on the final word.
   task automatic expect_stream(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         sb_data.push_back(8'(base + i));
         sb_last.push_back(((i + 1) % BURST_LEN == 0) || (i == n - 1));
      end
   endtask

   task automatic wait_drain(input string name, input int budget, input bit toggle);
      int n;
      n = 0;
      while ((sb_data.size() != 0 || busy || bus.m_valid) && n < budget) begin
         if (toggle) bus.m_ready = ~bus.m_ready;
         tick();
         n++;
      end
      check(name, 32'(sb_data.size() == 0 && !busy && !bus.m_valid), 1);
      bus.m_ready = 1'b1;
   endtask

   initial begin
      int w;
      int n;
      bus.m_ready = 1'b0;
      clear_stats();

      // Reset
      rrst = 1'b1;
      repeat (3) tick();
      rrst = 1'b0;
      #1;
      check("rst_m_valid", 32'(bus.m_valid), 0);
      check("rst_m_last", 32'(bus.m_last), 0);
      check("rst_m_data", 32'(bus.m_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_timeout_evt", 32'(timeout_evt), 0);
      bus.m_ready = 1'b1;
      tick();

      // T1: full burst, back-to-back
      clear_stats();
      w = cyc;
      write_words('h10, 8);
      expect_stream('h10, 8);
      wait_drain("t1_drain", 40, 1'b0);
      check("t1_rinc_cnt", 32'(rinc_cnt), 8);
      check("t1_first_rinc", 32'(first_rinc - w), 2);
      check("t1_rinc_run", 32'(last_rinc - first_rinc), 7);
      check("t1_beat_run", 32'(last_beat - first_beat), 7);
      check("t1_latency", 32'(first_beat - first_rinc), 1);
      check("t1_no_timeout", 32'(to_cnt), 0);

      // T2: partial burst forced by timeout
      clear_stats();
      w = cyc;
      write_words('hA0, 3);
      expect_stream('hA0, 3);
      wait_drain("t2_drain", 60, 1'b0);
      check("t2_to_cnt", 32'(to_cnt), 1);
      check("t2_to_cycle", 32'(to_cyc - w), 18);
      check("t2_first_rinc", 32'(first_rinc - w), 18);
      check("t2_rinc_cnt", 32'(rinc_cnt), 3);

      // T3: full burst with alternating m_ready
      clear_stats();
      write_words('h30, 8);
      expect_stream('h30, 8);
      wait_drain("t3_drain", 80, 1'b1);
      check("t3_rinc_cnt", 32'(rinc_cnt), 8);
      check("t3_beat_cnt", 32'(beat_cnt), 8);

      // T4: flush on the third WAIT cycle
      clear_stats();
      w = cyc;
      write_words('h40, 2);
      expect_stream('h40, 2);
      repeat (3) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_drain("t4_drain", 40, 1'b0);
      check("t4_first_rinc", 32'(first_rinc - w), 5);
      check("t4_no_timeout", 32'(to_cnt), 0);
      check("t4_rinc_cnt", 32'(rinc_cnt), 2);

      // T5: 20 words -> 8, 8, then 4 after timeout
      clear_stats();
      write_words('h50, 20);
      expect_stream('h50, 20);
      wait_drain("t5_drain", 120, 1'b0);
      check("t5_rinc_cnt", 32'(rinc_cnt), 20);
      check("t5_beat_cnt", 32'(beat_cnt), 20);
      check("t5_to_cnt", 32'(to_cnt), 1);

      // T7: depth reaching BURST_LEN during WAIT starts a full burst
      clear_stats();
      w = cyc;
      write_words('h90, 3);
      expect_stream('h90, 8);
      repeat (4) tick();
      write_words('h93, 5);
      wait_drain("t7_drain", 60, 1'b0);
      check("t7_no_timeout", 32'(to_cnt), 0);
      check("t7_first_rinc", 32'(first_rinc - w), 6);
      check("t7_rinc_cnt", 32'(rinc_cnt), 8);

      // T6: reset after beat 3 of an 8-beat burst
      clear_stats();
      write_words('h70, 8);
      for (int i = 0; i < 3; i++) begin
         sb_data.push_back(8'('h70 + i));
         sb_last.push_back(1'b0);
      end
      n = 0;
      while (beat_cnt < 3 && n < 40) begin
         tick();
         n++;
      end
      check("t6_reach_beat3", 32'(beat_cnt), 3);
      rrst = 1'b1;
      tick();
      check("t6_m_valid", 32'(bus.m_valid), 0);
      check("t6_m_last", 32'(bus.m_last), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_rinc", 32'(bus.rinc), 0);
      check("t6_sb_empty", 32'(sb_data.size()), 0);
      rrst = 1'b0;
      #1;
      check("t6_rinc_after", 32'(bus.rinc), 0);
      check("t6_busy_after", 32'(busy), 0);
      tick();
      clear_stats();
      write_words('hB0, 8);
      expect_stream('hB0, 8);
      wait_drain("t6_resume_drain", 40, 1'b0);
      check("t6_resume_rinc", 32'(rinc_cnt), 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
